// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if
//   Bundles the request/configuration inputs and the staged reset/enable
//   outputs of clk_rst_seq.
//   master : the controlling side (software/testbench). Drives requests and
//            per-channel configuration, observes resets, enables and status.
//   slave  : the sequencer itself.
//   Signals:
//     sw_rst_req  [NUM_CH]        per-channel software reset request
//     rel_delay   [NUM_CH*CNT_W]  per-channel extra release delay
//     div_ratio   [NUM_CH*DIV_W]  per-channel enable divide ratio
//     ch_reset_n  [NUM_CH]        active-low channel resets
//     ch_clk_en   [NUM_CH]        per-channel clock enables
//     seq_done, busy, req_drop    status
interface clk_rst_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 4
);
  logic [NUM_CH-1:0]       sw_rst_req;
  logic [NUM_CH*CNT_W-1:0] rel_delay;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH-1:0]       ch_reset_n;
  logic [NUM_CH-1:0]       ch_clk_en;
  logic                    seq_done;
  logic                    busy;
  logic                    req_drop;

  modport master (
    output sw_rst_req, rel_delay, div_ratio,
    input  ch_reset_n, ch_clk_en, seq_done, busy, req_drop
  );

  modport slave (
    input  sw_rst_req, rel_delay, div_ratio,
    output ch_reset_n, ch_clk_en, seq_done, busy, req_drop
  );
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq
//   Reset sequencer and clock-enable generator for NUM_CH channels.
//   After the global reset it holds all channel resets for MIN_PULSE cycles,
//   then releases channels 0..NUM_CH-1 in order, each after its own
//   rel_delay+1 cycles. Once the boot is done, each channel can be reset on
//   its own by a software request, and each channel has a divided enable.
//   Ports:
//     clk      block clock, rising edge
//     reset_n  synchronous active-low global reset
//     bus      clk_rst_seq_if.slave (requests, config, resets, enables, status)
module clk_rst_seq #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int DIV_W     = 4,
  parameter int MIN_PULSE = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  clk_rst_seq_if.slave  bus
);

  // Wide enough for MIN_PULSE + max delay + 1, which also covers the boot
  // pulse count and any single delay field.
  localparam int SW_W  = $clog2(MIN_PULSE + (1 << CNT_W) + 1);
  // The pointer must be able to hold NUM_CH (one past the last channel).
  localparam int PTR_W = $clog2(NUM_CH + 1);
  localparam int ARR_N = 1 << PTR_W;

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_DONE} state_t;

  state_t           state_q;
  logic [SW_W-1:0]  bcnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  logic             seq_done_q;
  logic             boot_fire;

  logic [CNT_W-1:0] rel_arr [ARR_N];
  logic [DIV_W-1:0] div_arr [NUM_CH];

  logic [NUM_CH-1:0] ch_reset_n_q, ch_reset_n_d;
  logic [SW_W-1:0]   swcnt_q [NUM_CH];
  logic [SW_W-1:0]   swcnt_d [NUM_CH];
  logic [DIV_W-1:0]  dcnt_q  [NUM_CH];
  logic [DIV_W-1:0]  dcnt_d  [NUM_CH];
  logic              req_drop_q, req_drop_d;
  logic [NUM_CH-1:0] clk_en_c;
  logic [NUM_CH-1:0] sw_active;

  // Padding entries beyond NUM_CH read as zero so the pointer can step past
  // the last channel without an out-of-range lookup.
  always_comb begin
    for (int i = 0; i < ARR_N; i++) rel_arr[i] = '0;
    for (int i = 0; i < NUM_CH; i++) rel_arr[i] = bus.rel_delay[i*CNT_W +: CNT_W];
    for (int i = 0; i < NUM_CH; i++) div_arr[i] = bus.div_ratio[i*DIV_W +: DIV_W];
  end

  assign ptr_nxt   = ptr_q + 1'b1;
  assign boot_fire = (state_q == ST_RELEASE) && (ptr_q != PTR_W'(NUM_CH)) && (bcnt_q == '0);

  // Boot FSM. The delay of the next channel is captured at the edge its
  // count starts, so later changes of the field do not disturb that count.
  // Once the last channel is released the pointer equals NUM_CH for one
  // cycle, which puts seq_done one edge after the last release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_ASSERT;
      bcnt_q     <= '0;
      ptr_q      <= '0;
      seq_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (bcnt_q == SW_W'(MIN_PULSE)) begin
            state_q <= ST_RELEASE;
            bcnt_q  <= SW_W'(rel_arr[0]);
            ptr_q   <= '0;
          end else begin
            bcnt_q  <= bcnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (ptr_q == PTR_W'(NUM_CH)) begin
            state_q    <= ST_DONE;
            seq_done_q <= 1'b1;
          end else if (bcnt_q == '0) begin
            ptr_q  <= ptr_nxt;
            bcnt_q <= SW_W'(rel_arr[ptr_nxt]);
          end else begin
            bcnt_q <= bcnt_q - 1'b1;
          end
        end
        ST_DONE: begin
        end
        default: state_q <= ST_ASSERT;
      endcase
    end
  end

  always_comb begin
    ch_reset_n_d = ch_reset_n_q;
    req_drop_d   = req_drop_q;
    clk_en_c     = '0;
    sw_active    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      swcnt_d[k] = swcnt_q[k];
      dcnt_d[k]  = '0;
    end

    if ((state_q != ST_DONE) && (|bus.sw_rst_req)) req_drop_d = 1'b1;

    for (int k = 0; k < NUM_CH; k++) begin
      sw_active[k] = (swcnt_q[k] != '0);

      if (boot_fire && (ptr_q == PTR_W'(k))) ch_reset_n_d[k] = 1'b1;

      // Software reset: the counter holds the remaining low cycles, so the
      // reset releases on the edge where it steps from 1 to 0. A new
      // request reloads the full length.
      if (state_q == ST_DONE) begin
        if (bus.sw_rst_req[k]) begin
          ch_reset_n_d[k] = 1'b0;
          swcnt_d[k]      = SW_W'(MIN_PULSE) + SW_W'(rel_arr[k]) + SW_W'(1);
        end else if (swcnt_q[k] == SW_W'(1)) begin
          ch_reset_n_d[k] = 1'b1;
          swcnt_d[k]      = '0;
        end else if (swcnt_q[k] != '0) begin
          swcnt_d[k]      = swcnt_q[k] - 1'b1;
        end
      end

      // Divider: held at 0 while in reset; '>=' folds a ratio lowered below
      // the current count back to 0 without emitting an enable.
      if (ch_reset_n_q[k]) begin
        clk_en_c[k] = (dcnt_q[k] == div_arr[k]);
        dcnt_d[k]   = (dcnt_q[k] >= div_arr[k]) ? '0 : dcnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_reset_n_q <= '0;
      req_drop_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) swcnt_q[k] <= '0;
    end else begin
      ch_reset_n_q <= ch_reset_n_d;
      req_drop_q   <= req_drop_d;
      for (int k = 0; k < NUM_CH; k++) swcnt_q[k] <= swcnt_d[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) dcnt_q[k] <= dcnt_d[k];
  end

  assign bus.ch_reset_n = ch_reset_n_q;
  assign bus.ch_clk_en  = clk_en_c;
  assign bus.seq_done   = seq_done_q;
  assign bus.busy       = (state_q != ST_DONE) || (|sw_active);
  assign bus.req_drop   = req_drop_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq
//   Scenario tasks drive reset, configuration and software requests; each
//   pushes the per-cycle expected outputs (from a timing model of the
//   sequencer) onto a queue and pops one entry per clock to compare.
module tb_clk_rst_seq;
  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 8;
  localparam int DIV_W     = 4;
  localparam int MIN_PULSE = 4;

  typedef struct packed {
    logic [NUM_CH-1:0] rst;
    logic [NUM_CH-1:0] en;
    logic              done;
    logic              busy;
    logic              drop;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  clk_rst_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  clk_rst_seq #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W), .MIN_PULSE(MIN_PULSE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   base   = 0;
  int   del  [NUM_CH] = '{2, 0, 5, 1};
  int   div  [NUM_CH] = '{0, 1, 3, 15};
  int   rise [NUM_CH];
  exp_t exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < NUM_CH; k++) begin
      bus.rel_delay[k*CNT_W +: CNT_W] = CNT_W'(del[k]);
      bus.div_ratio[k*DIV_W +: DIV_W] = DIV_W'(div[k]);
    end
  endtask

  function automatic logic en_at(int i, int r, int d);
    return (i >= r) && (((i - r) % (d + 1)) == d);
  endfunction

  // Expected outputs after boot edge i (edge 0 = first edge with reset_n=1).
  function automatic exp_t boot_exp(int i, bit drop);
    exp_t e;
    int   acc;
    e   = '0;
    acc = MIN_PULSE;
    for (int k = 0; k < NUM_CH; k++) begin
      acc     += del[k] + 1;
      rise[k]  = acc;
      e.rst[k] = (i >= acc);
      e.en[k]  = en_at(i, acc, div[k]);
    end
    e.done = (i >= acc + 1);
    e.busy = !e.done;
    e.drop = drop;
    return e;
  endfunction

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.sw_rst_req = '0;
    apply_cfg();
    step();
    step();
    checks++; if (bus.ch_reset_n !== 4'b0000) begin errors++; $display("FAIL reset_ch_reset_n got %b exp 0000", bus.ch_reset_n); end
    checks++; if (bus.ch_clk_en  !== 4'b0000) begin errors++; $display("FAIL reset_ch_clk_en got %b exp 0000", bus.ch_clk_en); end
    checks++; if (bus.seq_done   !== 1'b0)    begin errors++; $display("FAIL reset_seq_done got %b exp 0", bus.seq_done); end
    checks++; if (bus.busy       !== 1'b1)    begin errors++; $display("FAIL reset_busy got %b exp 1", bus.busy); end
    checks++; if (bus.req_drop   !== 1'b0)    begin errors++; $display("FAIL reset_req_drop got %b exp 0", bus.req_drop); end
  endtask

  // Caller leaves reset_n low; this releases it and follows the boot.
  // With inject set, sw_rst_req[1] is sampled at edge 10 (during RELEASE).
  task automatic test_boot(input string tag, input bit inject);
    exp_t e;
    exp_t obs;
    int   n;
    apply_cfg();
    reset_n = 1'b1;
    base    = cyc + 1;
    void'(boot_exp(0, 1'b0));
    n = rise[NUM_CH-1] + 4;
    for (int i = 0; i < n; i++) exp_q.push_back(boot_exp(i, inject && (i >= 10)));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      bus.sw_rst_req = (inject && i == 10) ? 4'b0010 : 4'b0000;
      step();
      obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s edge=%0d got %b exp %b (rst|en|done|busy|drop)", tag, i, obs, e);
      end
    end
    bus.sw_rst_req = '0;
  endtask

  task automatic test_clk_en();
    exp_t e;
    exp_t obs;
    int   i0;
    int   ie;
    i0 = cyc - base;
    ie = i0 + 33;
    while (((ie - rise[3]) % 16) != 9) ie++;
    for (int i = i0 + 1; i <= ie; i++) exp_q.push_back(boot_exp(i, 1'b0));
    for (int i = i0 + 1; i <= ie; i++) begin
      e = exp_q.pop_front();
      step();
      obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clk_en_period edge=%0d got %b exp %b (rst|en|done|busy|drop)", i, obs, e);
      end
    end
    // ch3 counter is 9 now; drop its ratio from 15 to 2.
    div[3] = 2;
    apply_cfg();
    #1;
    checks++;
    if (bus.ch_clk_en[3] !== 1'b0) begin
      errors++;
      $display("FAIL clk_en_lowered_ratio got %b exp 0", bus.ch_clk_en[3]);
    end
    for (int i = ie + 1; i <= ie + 12; i++) begin
      e = boot_exp(i, 1'b0);
      e.en[3] = (((i - (ie + 1)) % 3) == 2);
      exp_q.push_back(e);
    end
    for (int i = ie + 1; i <= ie + 12; i++) begin
      e = exp_q.pop_front();
      step();
      obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clk_en_ratio3 edge=%0d got %b exp %b (rst|en|done|busy|drop)", i, obs, e);
      end
    end
  endtask

  task automatic test_sw_reset();
    exp_t e;
    exp_t obs;
    int   n2;
    for (int k = 0; k < NUM_CH; k++) div[k] = 0;
    apply_cfg();
    step();
    step();
    checks++;
    if (bus.ch_clk_en !== 4'b1111) begin
      errors++;
      $display("FAIL sw_pre_enables got %b exp 1111", bus.ch_clk_en);
    end
    n2 = MIN_PULSE + del[2] + 1;
    for (int j = 0; j < 14; j++) begin
      e         = '0;
      e.rst     = 4'b1111;
      e.rst[2]  = (j >= n2);
      e.en      = e.rst;
      e.done    = 1'b1;
      e.busy    = (j < n2);
      exp_q.push_back(e);
    end
    for (int j = 0; j < 14; j++) begin
      e = exp_q.pop_front();
      bus.sw_rst_req = (j == 0) ? 4'b0100 : 4'b0000;
      step();
      obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL sw_reset_ch2 j=%0d got %b exp %b (rst|en|done|busy|drop)", j, obs, e);
      end
    end
    bus.sw_rst_req = '0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t obs;
    int   end0;
    int   end3;
    end0 = 3 + MIN_PULSE + del[0] + 1;
    end3 = 0 + MIN_PULSE + del[3] + 1;
    for (int j = 0; j < 14; j++) begin
      e        = '0;
      e.rst    = 4'b1111;
      e.rst[0] = (j >= end0);
      e.rst[3] = (j >= end3);
      e.en     = e.rst;
      e.done   = 1'b1;
      e.busy   = (j < end0) || (j < end3);
      exp_q.push_back(e);
    end
    for (int j = 0; j < 14; j++) begin
      e = exp_q.pop_front();
      bus.sw_rst_req = (j == 0) ? 4'b1001 : ((j == 3) ? 4'b0001 : 4'b0000);
      step();
      obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL sw_simul_extend j=%0d got %b exp %b (rst|en|done|busy|drop)", j, obs, e);
      end
    end
    bus.sw_rst_req = '0;
  endtask

  task automatic test_dropped_req();
    div = '{0, 1, 3, 15};
    reset_n = 1'b0;
    step();
    test_boot("drop_boot", 1'b1);
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if (bus.req_drop !== 1'b1) begin
        errors++;
        $display("FAIL drop_sticky j=%0d got %b exp 1", j, bus.req_drop);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    exp_t obs;
    del = '{2, 3, 5, 1};
    apply_cfg();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    base    = cyc + 1;
    for (int i = 0; i < 10; i++) exp_q.push_back(boot_exp(i, 1'b0));
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      step();
      obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_pre edge=%0d got %b exp %b (rst|en|done|busy|drop)", i, obs, e);
      end
    end
    reset_n = 1'b0;
    step();
    e      = '0;
    e.busy = 1'b1;
    obs = {bus.ch_reset_n, bus.ch_clk_en, bus.seq_done, bus.busy, bus.req_drop};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_abort got %b exp %b (rst|en|done|busy|drop)", obs, e);
    end
    test_boot("mid_restart", 1'b0);
  endtask

  initial begin
    test_reset();
    test_boot("boot", 1'b0);
    test_clk_en();
    test_sw_reset();
    test_back_to_back();
    test_dropped_req();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got cyc=%0d exp completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Parametrised, synthesizable reset sequencer and clock-enable generator for NUM_CH downstream channels, all driven from one clock and one global synchronous reset. After global reset it releases per-channel resets in a fixed order with programmable inter-channel delays. Once sequencing completes, each channel can be reset individually by software request, and each channel gets its own programmable divided clock-enable. It sits between the top-level clock/reset source and the peripheral blocks (UART, APB bridge, etc.), so the single clock/reset pair fans out into staged per-block resets and enables.

## Interface
- NUM_CH, 4: number of channels (1..16).
- CNT_W, 8: width of each per-channel release delay field.
- DIV_W, 4: width of each per-channel divide-ratio field.
- MIN_PULSE, 4: minimum reset assertion in cycles (>=1), applied after global reset and to every software reset.

- clk  in  1  single block clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low global reset.
- sw_rst_req  in  NUM_CH  per-channel software reset request, sampled each edge (level or pulse).
- rel_delay  in  NUM_CH*CNT_W  channel k field [k*CNT_W +: CNT_W], extra release delay in cycles.
- div_ratio  in  NUM_CH*DIV_W  channel k field [k*DIV_W +: DIV_W]; enable period = ratio+1 cycles.
- ch_reset_n  out  NUM_CH  registered active-low channel resets.
- ch_clk_en  out  NUM_CH  per-channel clock-enable.
- seq_done  out  1  boot sequence complete.
- busy  out  1  boot sequencing or any software reset in progress.
- req_drop  out  1  sticky: a software request arrived during boot sequencing.

## Operation
- Boot FSM states: ASSERT, RELEASE, DONE.
  - ASSERT: hold MIN_PULSE cycles.
  - RELEASE: channel pointer k = 0..NUM_CH-1. For each k, count rel_delay[k]+1 cycles, then set ch_reset_n[k]=1 and advance k. Channels release strictly in index order; released channels stay released.
  - After the last channel releases, go to DONE and set seq_done=1.
- Delay fields are sampled when each channel's count starts. Changing a field mid-count has no effect on that count.
- Software reset, DONE only:
  - sw_rst_req[k]=1 at an edge drives ch_reset_n[k] low for exactly MIN_PULSE+rel_delay[k]+1 cycles, starting the next cycle.
  - Channels are independent. Simultaneous requests on several channels each run their own counter.
  - A request on a channel already in software reset reloads its counter, extending the reset.
  - seq_done stays 1 throughout.
- Software requests outside DONE are ignored and set req_drop, which clears only on reset_n=0.
- Clock enable, per channel:
  - DIV_W-bit counter, held at 0 while ch_reset_n[k]=0.
  - ch_clk_en[k] = ch_reset_n[k] && (cnt==ratio), combinational from registered state.
  - Counter goes to 0 when cnt>=ratio, else increments. ratio 0 gives an enable every released cycle. ratio 2^DIV_W-1 gives a period of 2^DIV_W.
  - If ratio is lowered below cnt, no enable is asserted that cycle and the counter goes to 0.
- busy = (state != DONE) || any channel software-reset counter nonzero.

## Timing
- While reset_n=0 at an edge, the next-cycle outputs are: ch_reset_n=0, ch_clk_en=0, seq_done=0, busy=1, req_drop=0, FSM in ASSERT.
- reset_n low mid-operation (during sequencing, a software reset, or DONE) aborts everything at that edge. The boot restarts from ASSERT.
- Let edge 0 be the first edge sampling reset_n=1.
  - ch_reset_n[k] rises after edge MIN_PULSE + Σ_{j<=k}(rel_delay[j]+1).
  - seq_done rises one edge after ch_reset_n[NUM_CH-1].
- First ch_clk_en[k] is asserted in the cycle ch_reset_n[k] first reads 1 when ratio=0, else ratio cycles later.
- A software reset request at edge t drives ch_reset_n[k] low from edge t+1. It returns high at edge t+1+MIN_PULSE+rel_delay[k]+1. ch_clk_en[k] is 0 for that whole window.

## Test plan
- Boot ordering. NUM_CH=4, MIN_PULSE=4, delays {2,0,5,1}, reset_n released before edge 0.
  - Required: ch_reset_n[0..3] rise after edges 7, 8, 14, 16.
  - Required: seq_done=1 after edge 17; busy falls at the same edge; req_drop=0.
- Clock-enable periods. After boot, div_ratio {0,1,3,15}.
  - Required: enable periods of 1, 2, 4 and 16 cycles on ch_clk_en[0..3].
  - Required: ratio changed from 15 to 2 while cnt=9 gives no enable that cycle, then an enable every 3 cycles.
- Software reset. In DONE, pulse sw_rst_req[2] (delay 5) at edge t.
  - Required: ch_reset_n[2] low for edges t+1..t+10 (10 cycles); no ch_clk_en[2] during that window; other channels undisturbed; seq_done stays 1.
- Simultaneous and extension. Pulse sw_rst_req[0] and sw_rst_req[3] at the same edge, then re-pulse [0] 3 cycles later.
  - Required: ch3 low for 6 cycles.
  - Required: ch0 low for 3+7=10 cycles total.
  - Required: busy falls only after both are released.
- Dropped request. Assert sw_rst_req[1] during RELEASE.
  - Required: no effect on the sequence; req_drop=1 and stays 1 until the next reset_n=0.
- Mid-operation reset. Drop reset_n for 1 cycle while ch1 is counting down.
  - Required: all outputs return to reset values, then a full boot restart with identical timing measured from the new edge 0.
